// File: rtl/epmp_mem_if.sv
// EPMP memory interface: MAR/MDR registers and a single-byte read/write handshake
// with wait-state acknowledge and timeout, sequenced by the control unit.
module epmp_mem_if #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic        MAR_Load_En,
   input  logic        Addr_Inc,
   input  logic        Mem_Rd_Req,
   input  logic        Mem_Wr_Req,
   input  logic        MDR_Out_En,
   input  logic [7:0]  IBH,
   inout  wire  [7:0]  IBL,
   output logic [15:0] Mem_Addr,
   output logic        Mem_Rd,
   output logic        Mem_Wr,
   output logic [7:0]  Mem_Dout,
   input  logic [7:0]  Mem_Din,
   input  logic        Mem_Ack,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic [15:0] Debug_MAR
);

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StWr
   } state_e;

   localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mar_pend_q, mar_pend_d;
   logic        mar_pend_vld_q, mar_pend_vld_d;
   logic [7:0]  mdr_q, mdr_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  wait_q, wait_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        mar_upd;
   logic [15:0] mar_new;
   logic        finish;

   always_comb begin
      mar_upd = MAR_Load_En | Addr_Inc;
      mar_new = MAR_Load_En ? {IBH, IBL} : mar_q + 16'd1;
   end

   always_comb begin
      state_d        = state_q;
      mar_d          = mar_q;
      mar_pend_d     = mar_pend_q;
      mar_pend_vld_d = mar_pend_vld_q;
      mdr_d          = mdr_q;
      dout_d         = dout_q;
      wait_d         = wait_q;
      done_d         = 1'b0;
      err_d          = err_q;
      finish         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (Mem_Rd_Req || Mem_Wr_Req) begin
               err_d  = 1'b0;
               wait_d = 8'd0;
               if (Mem_Rd_Req) begin
                  state_d = StRd;
               end else begin
                  state_d = StWr;
                  dout_d  = IBL;
               end
               // A same-edge MAR update is deferred so the access keeps the old address.
               if (mar_upd) begin
                  mar_pend_d     = mar_new;
                  mar_pend_vld_d = 1'b1;
               end
            end else if (mar_upd) begin
               mar_d = mar_new;
            end
         end

         StRd, StWr: begin
            finish = Mem_Ack || (wait_q == WaitLast);
            if (finish) begin
               state_d = StIdle;
               done_d  = 1'b1;
               if (mar_pend_vld_q) begin
                  mar_d          = mar_pend_q;
                  mar_pend_vld_d = 1'b0;
               end
               if (Mem_Ack) begin
                  if (state_q == StRd) begin
                     mdr_d = Mem_Din;
                  end
               end else begin
                  err_d = 1'b1;
                  if (state_q == StRd) begin
                     mdr_d = 8'hFF;
                  end
               end
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q        <= StIdle;
         mar_q          <= 16'h0000;
         mar_pend_q     <= 16'h0000;
         mar_pend_vld_q <= 1'b0;
         mdr_q          <= 8'h00;
         dout_q         <= 8'h00;
         wait_q         <= 8'h00;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         mar_q          <= mar_d;
         mar_pend_q     <= mar_pend_d;
         mar_pend_vld_q <= mar_pend_vld_d;
         mdr_q          <= mdr_d;
         dout_q         <= dout_d;
         wait_q         <= wait_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign IBL       = MDR_Out_En ? mdr_q : 8'bz;
   assign Mem_Addr  = mar_q;
   assign Debug_MAR = mar_q;
   assign Mem_Rd    = (state_q == StRd);
   assign Mem_Wr    = (state_q == StWr);
   assign Busy      = (state_q != StIdle);
   assign Mem_Dout  = dout_q;
   assign Done      = done_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_epmp_mem_if.sv
// Scoreboard bench for epmp_mem_if: expected access results are queued at issue
// and compared when Done is seen.
module tb_epmp_mem_if;

   localparam int unsigned TO = 15;

   logic        clk = 1'b0;
   logic        nReset;
   logic        MAR_Load_En, Addr_Inc, Mem_Rd_Req, Mem_Wr_Req, MDR_Out_En;
   logic [7:0]  IBH;
   logic [7:0]  ibl_drv;
   logic        ibl_en;
   wire  [7:0]  IBL_w;
   logic [15:0] Mem_Addr, Debug_MAR;
   logic        Mem_Rd, Mem_Wr, Busy, Done, Err, Mem_Ack;
   logic [7:0]  Mem_Dout, Mem_Din;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       is_rd;
      logic [7:0] data;
      logic       err;
      int         strobes;
   } exp_t;

   exp_t sb[$];

   assign IBL_w = ibl_en ? ibl_drv : 8'bz;

   epmp_mem_if #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .nReset     (nReset),
      .MAR_Load_En(MAR_Load_En),
      .Addr_Inc   (Addr_Inc),
      .Mem_Rd_Req (Mem_Rd_Req),
      .Mem_Wr_Req (Mem_Wr_Req),
      .MDR_Out_En (MDR_Out_En),
      .IBH        (IBH),
      .IBL        (IBL_w),
      .Mem_Addr   (Mem_Addr),
      .Mem_Rd     (Mem_Rd),
      .Mem_Wr     (Mem_Wr),
      .Mem_Dout   (Mem_Dout),
      .Mem_Din    (Mem_Din),
      .Mem_Ack    (Mem_Ack),
      .Busy       (Busy),
      .Done       (Done),
      .Err        (Err),
      .Debug_MAR  (Debug_MAR)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_mdr(output logic [7:0] val);
      ibl_en     = 1'b0;
      MDR_Out_En = 1'b1;
      #1;
      val        = IBL_w;
      MDR_Out_En = 1'b0;
   endtask

   // ack_delay: number of edges Mem_Ack is sampled low before going high
   task automatic do_access(input logic rd, input logic wr, input logic [7:0] wdata,
                            input logic [7:0] din, input int ack_delay,
                            input logic [15:0] addr, input logic poke);
      exp_t e;
      int   rd_cyc = 0;
      int   wr_cyc = 0;
      bit   got = 0;
      logic [7:0] m;
      e.is_rd   = rd;
      e.err     = (ack_delay >= int'(TO));
      e.strobes = e.err ? int'(TO) : ack_delay + 1;
      e.data    = rd ? (e.err ? 8'hFF : din) : wdata;
      sb.push_back(e);

      Mem_Din    = din;
      Mem_Ack    = (ack_delay == 0);
      Mem_Rd_Req = rd;
      Mem_Wr_Req = wr;
      ibl_drv    = wdata;
      ibl_en     = 1'b1;
      step();
      Mem_Rd_Req  = 1'b0;
      Mem_Wr_Req  = 1'b0;
      MAR_Load_En = 1'b0;
      Addr_Inc    = 1'b0;
      ibl_en      = 1'b0;
      chk("err_clr", {31'd0, Err}, 32'd0);
      chk("busy", {31'd0, Busy}, 32'd1);

      for (int j = 1; j <= 40 && !got; j++) begin
         if (Mem_Rd) rd_cyc++;
         if (Mem_Wr) wr_cyc++;
         chk("addr_stable", {16'd0, Mem_Addr}, {16'd0, addr});
         if (!rd) chk("dout_hold", {24'd0, Mem_Dout}, {24'd0, wdata});
         if (poke && j == 2) begin
            MAR_Load_En = 1'b1;
            Addr_Inc    = 1'b1;
            IBH         = 8'hDE;
            ibl_drv     = 8'hAD;
            ibl_en      = 1'b1;
         end else begin
            MAR_Load_En = 1'b0;
            Addr_Inc    = 1'b0;
            ibl_en      = 1'b0;
         end
         Mem_Ack = (j > ack_delay);
         step();
         if (Done) got = 1;
      end
      Mem_Ack     = 1'b0;
      MAR_Load_En = 1'b0;
      Addr_Inc    = 1'b0;
      ibl_en      = 1'b0;

      e = sb.pop_front();
      if (!got) begin
         chk("done_seen", 32'd0, 32'd1);
      end else begin
         chk("rd_cycles", rd_cyc, e.is_rd ? e.strobes : 0);
         chk("wr_cycles", wr_cyc, e.is_rd ? 0 : e.strobes);
         chk("err", {31'd0, Err}, {31'd0, e.err});
         chk("idle_at_done", {30'd0, Mem_Rd | Mem_Wr, Busy}, 32'd0);
         if (e.is_rd) begin
            read_mdr(m);
            chk("mdr", {24'd0, m}, {24'd0, e.data});
         end else begin
            chk("dout", {24'd0, Mem_Dout}, {24'd0, e.data});
         end
         step();
         chk("done_pulse", {31'd0, Done}, 32'd0);
      end
   endtask

   initial begin
      logic [7:0] m;
      int done_cnt;
      nReset      = 1'b0;
      MAR_Load_En = 1'b0;
      Addr_Inc    = 1'b0;
      Mem_Rd_Req  = 1'b0;
      Mem_Wr_Req  = 1'b0;
      MDR_Out_En  = 1'b0;
      IBH         = 8'h00;
      ibl_drv     = 8'h00;
      ibl_en      = 1'b0;
      Mem_Din     = 8'h00;
      Mem_Ack     = 1'b0;
      #3;
      chk("rst_addr", {16'd0, Mem_Addr}, 32'd0);
      chk("rst_flags", {26'd0, Mem_Rd, Mem_Wr, Busy, Done, Err, 1'b0}, 32'd0);
      chk("rst_dout", {24'd0, Mem_Dout}, 32'd0);
      read_mdr(m);
      chk("rst_mdr", {24'd0, m}, 32'd0);
      nReset = 1'b1;
      step();

      // Load MAR from the bus
      IBH = 8'h12; ibl_drv = 8'h34; ibl_en = 1'b1; MAR_Load_En = 1'b1;
      step();
      MAR_Load_En = 1'b0;
      chk("load_addr", {16'd0, Mem_Addr}, 32'h1234);
      chk("debug_mar", {16'd0, Debug_MAR}, 32'h1234);
      ibl_drv = 8'h3C; ibl_en = 1'b1; MDR_Out_En = 1'b0;
      #1;
      chk("ibl_released", {24'd0, IBL_w}, 32'h3C);
      ibl_en = 1'b0;

      do_access(1'b1, 1'b0, 8'h00, 8'hA5, 0, 16'h1234, 1'b0);     // zero-wait read
      do_access(1'b0, 1'b1, 8'h5A, 8'h00, 3, 16'h1234, 1'b0);     // wait-state write
      do_access(1'b1, 1'b0, 8'h00, 8'h99, 1000, 16'h1234, 1'b0);  // timeout
      chk("err_sticky", {31'd0, Err}, 32'd1);
      do_access(1'b1, 1'b0, 8'h00, 8'h3C, 1, 16'h1234, 1'b0);

      // Wrap
      IBH = 8'hFF; ibl_drv = 8'hFF; ibl_en = 1'b1; MAR_Load_En = 1'b1;
      step();
      MAR_Load_En = 1'b0; ibl_en = 1'b0;
      chk("load_ffff", {16'd0, Mem_Addr}, 32'hFFFF);
      Addr_Inc = 1'b1;
      step();
      Addr_Inc = 1'b0;
      chk("wrap", {16'd0, Mem_Addr}, 32'h0000);

      do_access(1'b1, 1'b1, 8'h66, 8'h77, 0, 16'h0000, 1'b0);     // read wins
      do_access(1'b1, 1'b0, 8'h00, 8'h11, 4, 16'h0000, 1'b1);     // ignored MAR pokes
      chk("poke_ignored", {16'd0, Mem_Addr}, 32'h0000);

      // MAR load on the same edge as a request is deferred past the access
      IBH = 8'h40; MAR_Load_En = 1'b1;
      do_access(1'b0, 1'b1, 8'h00, 8'h00, 2, 16'h0000, 1'b0);
      chk("deferred_load", {16'd0, Mem_Addr}, 32'h4000);

      // Reset mid-access
      Mem_Rd_Req = 1'b1;
      step();
      Mem_Rd_Req = 1'b0;
      step();
      step();
      #2;
      nReset = 1'b0;
      #1;
      chk("mid_rst_strobe", {30'd0, Mem_Rd, Busy}, 32'd0);
      chk("mid_rst_addr", {16'd0, Mem_Addr}, 32'd0);
      #3;
      nReset = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (Done) done_cnt++;
      end
      chk("no_done_after_rst", done_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/epmp_mem_if.md
# epmp_mem_if

Memory interface for the EPMP datapath: the consumer of addresses the program counter and other sources drive onto the internal bus (IBH/IBL). It captures a 16-bit address from the bus into a memory address register (MAR) and runs a single-byte read or write handshake with external memory, with a wait-state acknowledge and a timeout. It returns read data to the bus through a memory data register (MDR). It sits between the internal bus and the program/data memory and is sequenced by the control unit.

## Interface
- TIMEOUT_CYCLES, 15: cycles in an access state without Mem_Ack before the access is aborted. Legal range is 1..255.

- clk  input  1  system clock; all registers update on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- MAR_Load_En  input  1  captures {IBH, IBL} into the MAR.
- Addr_Inc  input  1  increments the MAR by 1.
- Mem_Rd_Req  input  1  starts a read from the MAR address.
- Mem_Wr_Req  input  1  starts a write of IBL to the MAR address.
- MDR_Out_En  input  1  drives the MDR onto IBL.
- IBH  input  8  internal bus high byte. This block never drives it.
- IBL  inout  8  internal bus low byte. Driven with the MDR when MDR_Out_En=1, otherwise 8'bZ.
- Mem_Addr  output  16  memory address; always equals the MAR.
- Mem_Rd  output  1  read strobe, held high for the whole read access.
- Mem_Wr  output  1  write strobe, held high for the whole write access.
- Mem_Dout  output  8  write data register.
- Mem_Din  input  8  read data, valid when Mem_Ack=1.
- Mem_Ack  input  1  memory acknowledge, sampled on clk.
- Busy  output  1  high while an access is in progress (RD or WR state).
- Done  output  1  one-cycle pulse when an access completes or times out.
- Err  output  1  sticky timeout flag.
- Debug_MAR  output  16  copy of the MAR.

## Operation
- FSM states: IDLE, RD, WR.
  - Busy = (state != IDLE).
  - Mem_Rd = (state == RD).
  - Mem_Wr = (state == WR).
- IDLE:
  - Mem_Rd_Req=1 → RD. Clears Err, clears the wait counter.
  - Otherwise Mem_Wr_Req=1 → WR. Latches IBL into Mem_Dout, clears Err, clears the wait counter.
  - If both requests are high, the read wins and the write is dropped.
- IDLE, MAR update:
  - MAR_Load_En=1 → MAR <= {IBH, IBL}.
  - Otherwise Addr_Inc=1 → MAR <= MAR+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - If MAR_Load_En and a request are high at the same edge, the access uses the old MAR value. The new MAR applies from the next access.
- RD / WR, each edge:
  - Mem_Ack=1 → IDLE with Done=1. In RD, the MDR also loads Mem_Din.
  - Otherwise, if wait counter == TIMEOUT_CYCLES-1 → IDLE with Done=1 and Err=1. In RD, MDR <= 8'hFF. In WR, the write is abandoned.
  - Otherwise the wait counter increments (8-bit counter).
- While Busy, MAR_Load_En, Addr_Inc, Mem_Rd_Req and Mem_Wr_Req are ignored. The MAR and Mem_Dout stay stable for the whole access.
- MDR_Out_En is purely combinational onto IBL in every state. Avoiding bus contention is the control unit's responsibility.
- Err stays set until the next accepted request.

## Timing
- All outputs reset to 0 when nReset=0, immediately and independently of clk: MAR, MDR, Mem_Dout, Mem_Rd, Mem_Wr, Busy, Done, Err and the wait counter. The state returns to IDLE and IBL goes to 8'bZ.
- Reset asserted mid-access drops the strobes at once. No Done is generated.
- Zero-wait read:
  - Request sampled at edge 0; Mem_Rd and Busy go high after edge 0.
  - Mem_Ack sampled high at edge 1; after edge 1 Mem_Rd=0, Busy=0, Done=1, and the MDR is valid.
  - Done is low again after edge 2.
- Each extra wait cycle (Mem_Ack=0) adds one cycle.
- Timeout: the strobe is high for exactly TIMEOUT_CYCLES cycles, then Done and Err go high together.
- A new request may be issued in the same cycle Done is high (state is IDLE). Back-to-back zero-wait accesses therefore take 2 cycles each.
- Mem_Ack while in IDLE is ignored.

## Test plan
- Reset and load:
  - Stimulus: release nReset, drive IBH=8'h12, IBL=8'h34, pulse MAR_Load_En.
  - Required: Mem_Addr=16'h1234 after the edge; IBL is Z while MDR_Out_En=0.
- Zero-wait read:
  - Stimulus: Mem_Rd_Req with Mem_Din=8'hA5 and Mem_Ack held high.
  - Required: Mem_Rd high for exactly 1 cycle, then a 1-cycle Done pulse; with MDR_Out_En=1, IBL=8'hA5.
- Wait-state write:
  - Stimulus: IBL=8'h5A, Mem_Wr_Req, Mem_Ack low for 3 cycles then high.
  - Required: Mem_Wr high for 4 cycles, Mem_Dout=8'h5A throughout, Done pulse, Err=0.
- Timeout (TIMEOUT_CYCLES=15):
  - Stimulus: read with Mem_Ack held low.
  - Required: Mem_Rd high for 15 cycles, then Done=1 and Err=1, MDR=8'hFF; the next request clears Err.
- Wrap and priorities:
  - Stimulus 1: MAR=16'hFFFF, pulse Addr_Inc.
  - Required: MAR becomes 16'h0000.
  - Stimulus 2: assert Mem_Rd_Req and Mem_Wr_Req together.
  - Required: a read occurs and no write occurs.
  - Stimulus 3: pulse MAR_Load_En and Addr_Inc while Busy.
  - Required: the MAR is unchanged.
- Reset mid-access:
  - Stimulus: assert nReset=0 two cycles into a waited read, between clock edges.
  - Required: Mem_Rd, Busy and the MAR go to 0 immediately; no Done pulse after release.
